// File: rtl/uart_line_echo.sv
// Line echo client: gathers received bytes into a line (with backspace editing) and echoes it plus CR LF.
// Latency: first echo push at least 2 edges after the terminator is consumed; pushes and pops at most 1 per 2 cycles.
// Backpressure: tx_full stalls every push with tx_data and rd_ptr held; no bytes are popped while busy.
module uart_line_echo #(
  parameter int LINE_MAX = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic [7:0] tx_data,
  output logic       tx_push,
  output logic       busy,
  output logic       line_trunc
);

  localparam int CW = $clog2(LINE_MAX + 1);
  localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam logic [CW-1:0] LINE_MAX_C = CW'(LINE_MAX);

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_BS = 8'h08;

  typedef enum logic [1:0] {COLLECT, EMIT, SEND_CR, SEND_LF} state_t;

  state_t        state, state_nxt;
  logic [7:0]    line_buf [LINE_MAX];
  logic [CW-1:0] count, count_nxt;
  logic [CW-1:0] rd_ptr, rd_ptr_nxt;
  logic          prev_cr, prev_cr_nxt;
  logic          rx_pop_nxt, tx_push_nxt, trunc_nxt, wr_en;
  logic [7:0]    tx_data_nxt;
  logic          can_push;

  // A push needs a free FIFO slot and a quiet previous edge; the rx_pop term
  // also keeps the first echo push two edges clear of the terminator pop.
  assign can_push = !tx_full && !tx_push && !rx_pop;

  // Next-state and output decode; every target defaults to hold / idle.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    rd_ptr_nxt  = rd_ptr;
    prev_cr_nxt = prev_cr;
    rx_pop_nxt  = 1'b0;
    tx_push_nxt = 1'b0;
    tx_data_nxt = tx_data;
    trunc_nxt   = 1'b0;
    wr_en       = 1'b0;
    case (state)
      COLLECT: begin
        // rx_pop high means the FIFO head is still being advanced; skip this edge.
        if (rx_valid && !rx_pop) begin
          rx_pop_nxt = 1'b1;
          case (rx_data)
            CHAR_CR: begin
              state_nxt   = EMIT;
              rd_ptr_nxt  = '0;
              prev_cr_nxt = 1'b1;
            end
            CHAR_LF: begin
              if (prev_cr) begin
                prev_cr_nxt = 1'b0;
              end else begin
                state_nxt  = EMIT;
                rd_ptr_nxt = '0;
              end
            end
            CHAR_BS: begin
              if (count != '0) count_nxt = count - CW'(1);
              prev_cr_nxt = 1'b0;
            end
            default: begin
              wr_en       = 1'b1;
              count_nxt   = count + CW'(1);
              prev_cr_nxt = 1'b0;
              if (count_nxt == LINE_MAX_C) begin
                state_nxt  = EMIT;
                rd_ptr_nxt = '0;
                trunc_nxt  = 1'b1;
              end
            end
          endcase
        end
      end
      EMIT: begin
        if (rd_ptr == count) begin
          state_nxt = SEND_CR;
        end else if (can_push) begin
          tx_push_nxt = 1'b1;
          tx_data_nxt = line_buf[rd_ptr[AW-1:0]];
          rd_ptr_nxt  = rd_ptr + CW'(1);
        end
      end
      SEND_CR: begin
        if (can_push) begin
          tx_push_nxt = 1'b1;
          tx_data_nxt = CHAR_CR;
          state_nxt   = SEND_LF;
        end
      end
      SEND_LF: begin
        if (can_push) begin
          tx_push_nxt = 1'b1;
          tx_data_nxt = CHAR_LF;
          count_nxt   = '0;
          state_nxt   = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // State and registered outputs; reset drops any partial line immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= COLLECT;
      count      <= '0;
      rd_ptr     <= '0;
      prev_cr    <= 1'b0;
      rx_pop     <= 1'b0;
      tx_push    <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      line_trunc <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      rd_ptr     <= rd_ptr_nxt;
      prev_cr    <= prev_cr_nxt;
      rx_pop     <= rx_pop_nxt;
      tx_push    <= tx_push_nxt;
      tx_data    <= tx_data_nxt;
      busy       <= (state_nxt != COLLECT);
      line_trunc <= trunc_nxt;
    end
  end

  // Line storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) line_buf[count[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_line_echo.sv
// Bench for uart_line_echo: queue-based RX FIFO, push monitor and a line-level reference model.
// Latency: checks compare full echoed byte streams once the block has gone idle.
// Backpressure: tx_full driven forced or randomly; monitor records protocol violations.
module tb_uart_line_echo;

  localparam int LINE_MAX = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_pop;
  logic       tx_full = 1'b0;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       busy;
  logic       line_trunc;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_line[$];
  bit         m_prev_cr = 1'b0;
  int         exp_trunc = 0;

  int pop_cnt = 0, trunc_cnt = 0, viol_full = 0, viol_b2b = 0, viol_pop_b2b = 0;
  bit rand_full = 1'b0, force_full = 1'b0;
  bit last_push = 1'b0, last_pop = 1'b0;

  uart_line_echo #(.LINE_MAX(LINE_MAX)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_pop     (rx_pop),
    .tx_full    (tx_full),
    .tx_data    (tx_data),
    .tx_push    (tx_push),
    .busy       (busy),
    .line_trunc (line_trunc)
  );

  always #5 clk = ~clk;

  // Receive FIFO model: advances on the negedge inside the rx_pop cycle.
  always @(negedge clk) begin
    if (!n_rst) rx_q.delete();
    else if (rx_pop && rx_q.size() > 0) void'(rx_q.pop_front());
    rx_valid = (rx_q.size() > 0);
    rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    tx_full  = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
  end

  // Output monitor: logs pushes, pops and truncation pulses, counts handshake violations.
  always @(posedge clk) begin
    bit f;
    f = tx_full;
    #1;
    if (!n_rst) begin
      last_push = 1'b0;
      last_pop  = 1'b0;
    end else begin
      if (tx_push) begin
        out_q.push_back(tx_data);
        if (f) viol_full++;
        if (last_push) viol_b2b++;
      end
      if (rx_pop) begin
        pop_cnt++;
        if (last_pop) viol_pop_b2b++;
      end
      if (line_trunc) trunc_cnt++;
      last_push = tx_push;
      last_pop  = rx_pop;
    end
  end

  // Reference model: line editing expressed on a byte queue.
  task automatic m_emit();
    foreach (m_line[i]) exp_q.push_back(m_line[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    m_line.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0D) begin
      m_emit();
      m_prev_cr = 1'b1;
    end else if (b == 8'h0A) begin
      if (m_prev_cr) m_prev_cr = 1'b0;
      else m_emit();
    end else if (b == 8'h08) begin
      if (m_line.size() > 0) void'(m_line.pop_back());
      m_prev_cr = 1'b0;
    end else begin
      m_line.push_back(b);
      m_prev_cr = 1'b0;
      if (m_line.size() == LINE_MAX) begin
        m_emit();
        exp_trunc++;
      end
    end
  endtask

  task automatic feed(input logic [7:0] b);
    rx_q.push_back(b);
    model_byte(b);
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    int stable;
    stable = 0;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && !busy && !tx_push && !rx_pop) stable++;
      else stable = 0;
      if (stable >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL reset_rx_pop: got %b want 0", rx_pop); end
    checks++; if (tx_push !== 1'b0) begin failures++; $display("FAIL reset_tx_push: got %b want 0", tx_push); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (line_trunc !== 1'b0) begin failures++; $display("FAIL reset_line_trunc: got %b want 0", line_trunc); end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int ob, eb, pb, no, ne;
    bit ok;
    ob = out_q.size(); eb = exp_q.size(); pb = pop_cnt;
    feed(8'h41); feed(8'h42); feed(8'h0D);
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_idle: block did not go idle within 300 cycles"); end
    no = out_q.size() - ob; ne = exp_q.size() - eb;
    checks++; if (no !== ne) begin failures++; $display("FAIL basic_len: got %0d bytes want %0d", no, ne); end
    for (int i = 0; i < ne && i < no; i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[eb+i]) begin failures++; $display("FAIL basic_byte[%0d]: got %02h want %02h", i, out_q[ob+i], exp_q[eb+i]); end
    end
    checks++; if (pop_cnt - pb !== 3) begin failures++; $display("FAIL basic_pops: got %0d want 3", pop_cnt - pb); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b want 0", busy); end
  endtask

  task automatic test_crlf();
    int ob, eb, pb, no, ne;
    bit ok;
    ob = out_q.size(); eb = exp_q.size(); pb = pop_cnt;
    feed(8'h41); feed(8'h0D); feed(8'h0A);
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL crlf_idle1: block did not go idle within 300 cycles"); end
    checks++; if (pop_cnt - pb !== 3) begin failures++; $display("FAIL crlf_pops: got %0d want 3", pop_cnt - pb); end
    feed(8'h0A);
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL crlf_idle2: block did not go idle within 300 cycles"); end
    no = out_q.size() - ob; ne = exp_q.size() - eb;
    checks++; if (no !== ne) begin failures++; $display("FAIL crlf_len: got %0d bytes want %0d", no, ne); end
    for (int i = 0; i < ne && i < no; i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[eb+i]) begin failures++; $display("FAIL crlf_byte[%0d]: got %02h want %02h", i, out_q[ob+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_edit();
    int ob, eb, no, ne;
    bit ok;
    ob = out_q.size(); eb = exp_q.size();
    feed(8'h41); feed(8'h42); feed(8'h08); feed(8'h43); feed(8'h0D);
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL edit_idle1: block did not go idle within 300 cycles"); end
    feed(8'h08);
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL edit_idle2: block did not go idle within 300 cycles"); end
    no = out_q.size() - ob; ne = exp_q.size() - eb;
    checks++; if (no !== ne) begin failures++; $display("FAIL edit_len: got %0d bytes want %0d", no, ne); end
    for (int i = 0; i < ne && i < no; i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[eb+i]) begin failures++; $display("FAIL edit_byte[%0d]: got %02h want %02h", i, out_q[ob+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_overflow();
    int ob, eb, tb0, et0, no, ne;
    bit ok;
    ob = out_q.size(); eb = exp_q.size(); tb0 = trunc_cnt; et0 = exp_trunc;
    feed(8'h41); feed(8'h42); feed(8'h43); feed(8'h44); feed(8'h45); feed(8'h0D);
    wait_idle(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_idle: block did not go idle within 400 cycles"); end
    no = out_q.size() - ob; ne = exp_q.size() - eb;
    checks++; if (no !== ne) begin failures++; $display("FAIL ovf_len: got %0d bytes want %0d", no, ne); end
    for (int i = 0; i < ne && i < no; i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[eb+i]) begin failures++; $display("FAIL ovf_byte[%0d]: got %02h want %02h", i, out_q[ob+i], exp_q[eb+i]); end
    end
    checks++;
    if (trunc_cnt - tb0 !== exp_trunc - et0) begin failures++; $display("FAIL ovf_trunc: got %0d pulses want %0d", trunc_cnt - tb0, exp_trunc - et0); end
  endtask

  task automatic test_backpressure();
    int ob, eb, no, ne, n_at;
    bit ok;
    ob = out_q.size(); eb = exp_q.size();
    feed(8'h41); feed(8'h42); feed(8'h43); feed(8'h0D);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_q.size() > ob) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL bp_first_push: no push within 200 cycles"); end
    force_full = 1'b1;
    @(negedge clk);
    n_at = out_q.size();
    repeat (10) @(negedge clk);
    checks++; if (out_q.size() !== n_at) begin failures++; $display("FAIL bp_stall: got %0d pushes while full want 0", out_q.size() - n_at); end
    force_full = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_idle: block did not go idle within 300 cycles"); end
    no = out_q.size() - ob; ne = exp_q.size() - eb;
    checks++; if (no !== ne) begin failures++; $display("FAIL bp_len: got %0d bytes want %0d", no, ne); end
    for (int i = 0; i < ne && i < no; i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[eb+i]) begin failures++; $display("FAIL bp_byte[%0d]: got %02h want %02h", i, out_q[ob+i], exp_q[eb+i]); end
    end
    checks++; if (viol_full !== 0) begin failures++; $display("FAIL bp_push_when_full: got %0d want 0", viol_full); end
    checks++; if (viol_b2b !== 0) begin failures++; $display("FAIL bp_push_b2b: got %0d want 0", viol_b2b); end
  endtask

  task automatic test_reset_mid();
    int ob, eb, no, ne, n_at;
    bit ok;
    ob = out_q.size();
    feed(8'h41); feed(8'h42); feed(8'h43); feed(8'h0D);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_q.size() >= ob + 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_two_pushes: not reached within 200 cycles"); end
    #1 n_rst = 1'b0;
    #1;
    checks++; if (tx_push !== 1'b0) begin failures++; $display("FAIL rstmid_tx_push: got %b want 0", tx_push); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx_data: got %02h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL rstmid_rx_pop: got %b want 0", rx_pop); end
    checks++; if (line_trunc !== 1'b0) begin failures++; $display("FAIL rstmid_line_trunc: got %b want 0", line_trunc); end
    m_line.delete();
    m_prev_cr = 1'b0;
    n_at = out_q.size();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (out_q.size() !== n_at) begin failures++; $display("FAIL rstmid_no_push: got %0d extra pushes want 0", out_q.size() - n_at); end
    ob = out_q.size(); eb = exp_q.size();
    feed(8'h5A); feed(8'h0D);
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_idle: block did not go idle within 300 cycles"); end
    no = out_q.size() - ob; ne = exp_q.size() - eb;
    checks++; if (no !== ne) begin failures++; $display("FAIL rstmid_len: got %0d bytes want %0d", no, ne); end
    for (int i = 0; i < ne && i < no; i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[eb+i]) begin failures++; $display("FAIL rstmid_byte[%0d]: got %02h want %02h", i, out_q[ob+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_random();
    int ob, eb, tb0, et0, no, ne, r;
    bit ok;
    logic [7:0] b;
    ob = out_q.size(); eb = exp_q.size(); tb0 = trunc_cnt; et0 = exp_trunc;
    rand_full = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) b = 8'h41 + 8'($urandom_range(0, 25));
      else if (r < 75) b = 8'h0D;
      else if (r < 85) b = 8'h0A;
      else b = 8'h08;
      feed(b);
    end
    wait_idle(20000, ok);
    rand_full = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL rand_idle: block did not go idle within 20000 cycles"); end
    no = out_q.size() - ob; ne = exp_q.size() - eb;
    checks++; if (no !== ne) begin failures++; $display("FAIL rand_len: got %0d bytes want %0d", no, ne); end
    for (int i = 0; i < ne && i < no; i++) begin
      checks++;
      if (out_q[ob+i] !== exp_q[eb+i]) begin failures++; $display("FAIL rand_byte[%0d]: got %02h want %02h", i, out_q[ob+i], exp_q[eb+i]); end
    end
    checks++;
    if (trunc_cnt - tb0 !== exp_trunc - et0) begin failures++; $display("FAIL rand_trunc: got %0d pulses want %0d", trunc_cnt - tb0, exp_trunc - et0); end
    checks++; if (viol_full !== 0) begin failures++; $display("FAIL rand_push_when_full: got %0d want 0", viol_full); end
    checks++; if (viol_b2b !== 0) begin failures++; $display("FAIL rand_push_b2b: got %0d want 0", viol_b2b); end
    checks++; if (viol_pop_b2b !== 0) begin failures++; $display("FAIL rand_pop_b2b: got %0d want 0", viol_pop_b2b); end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_crlf();
    test_edit();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
